current_sense_spi: RTL and testbench

- Round-robin SPI master that reads the three phase-current ADCs over a shared SCK/MISO bus, with one active-low chip select per phase.
- Produces the current_phase1..3 words that the coms block reports upstream. Sits between the board-level current-sensor pins and coms.
- Runs on the 32 MHz PLL clock.

---
 rtl/current_sense_pkg.sv | 25 ++
 rtl/current_avg4.sv | 40 ++++
 rtl/current_sense_spi.sv | 165 ++++++++++++++++
 tb/tb_current_sense_spi.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/current_sense_pkg.sv
// Shared types and constants for the phase-current SPI reader.
package current_sense_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned NUM_CH     = 3;

  typedef logic [1:0] ch_t;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StShift,
    StDeselect
  } state_e;

  function automatic ch_t next_ch(ch_t ch);
    return (ch == ch_t'(NUM_CH - 1)) ? ch_t'(0) : ch + ch_t'(1);
  endfunction

  // Active-low select pattern with only the bit for ch cleared.
  function automatic logic [NUM_CH-1:0] cs_mask(ch_t ch);
    return ~(NUM_CH'(1) << ch);
  endfunction

endpackage

// File: rtl/current_avg4.sv
// Four-sample running average for one phase: history of raw words and 18-bit sum.
module current_avg4
  import current_sense_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] din,
  output logic [FRAME_BITS-1:0] dout
);

  logic [3:0][FRAME_BITS-1:0] hist_q, hist_d;
  logic [FRAME_BITS-1:0]      dout_q, dout_d;
  logic [FRAME_BITS+1:0]      sum;

  always_comb begin
    hist_d = hist_q;
    dout_d = dout_q;
    sum    = '0;
    if (load) begin
      hist_d = {hist_q[2:0], din};
      sum    = (FRAME_BITS+2)'(hist_d[0]) + (FRAME_BITS+2)'(hist_d[1]) +
               (FRAME_BITS+2)'(hist_d[2]) + (FRAME_BITS+2)'(hist_d[3]);
      dout_d = sum[FRAME_BITS+1:2];
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      hist_q <= '0;
      dout_q <= '0;
    end else begin
      hist_q <= hist_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/current_sense_spi.sv
// Round-robin SPI master reading three phase-current ADCs (CPOL=1, MSB first).
// Define CURRENT_AVG_EN to report a four-sample average instead of raw words.
module current_sense_spi
  import current_sense_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned GAP      = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  miso,
  output logic                  sck,
  output logic [NUM_CH-1:0]     ss_n,
  output logic [FRAME_BITS-1:0] current_phase1,
  output logic [FRAME_BITS-1:0] current_phase2,
  output logic [FRAME_BITS-1:0] current_phase3,
  output logic [NUM_CH-1:0]     sample_valid
);

  localparam int unsigned BitW = $clog2(FRAME_BITS);

  state_e                state_q, state_d;
  ch_t                   ch_q, ch_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  sck_q, sck_d;
  logic [NUM_CH-1:0]     ss_n_q, ss_n_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]            sync_q, sync_d;
  logic [NUM_CH-1:0]     valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q + 8'd1;
    bit_d   = bit_q;
    sck_d   = sck_q;
    ss_n_d  = ss_n_q;
    shreg_d = shreg_q;
    sync_d  = {sync_q[0], miso};
    valid_d = '0;
    unique case (state_q)
      StIdle: begin
        sck_d  = 1'b1;
        ss_n_d = '1;
        cnt_d  = '0;
        if (enable) begin
          state_d = StSelect;
          ss_n_d  = cs_mask(ch_q);
        end
      end
      StSelect: begin
        if (cnt_q == 8'(CS_SETUP - 1)) begin
          state_d = StShift;
          sck_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (cnt_q == 8'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sck_q) begin
            // Rising SCK edge: capture the synchronized data bit.
            sck_d   = 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], sync_q[1]};
          end else if (bit_q == BitW'(FRAME_BITS - 1)) begin
            state_d = StDeselect;
            ss_n_d  = '1;
            valid_d = ~cs_mask(ch_q);
          end else begin
            sck_d = 1'b0;
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StDeselect: begin
        if (cnt_q == 8'(GAP - 1)) begin
          cnt_d = '0;
          ch_d  = next_ch(ch_q);
          if (enable) begin
            state_d = StSelect;
            ss_n_d  = cs_mask(next_ch(ch_q));
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b1;
      ss_n_q  <= '1;
      shreg_q <= '0;
      sync_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      ss_n_q  <= ss_n_d;
      shreg_q <= shreg_d;
      sync_q  <= sync_d;
      valid_q <= valid_d;
    end
  end

  assign sck          = sck_q;
  assign ss_n         = ss_n_q;
  assign sample_valid = valid_q;

`ifdef CURRENT_AVG_EN
  current_avg4 u_avg_ph1 (
    .CLK  (CLK),
    .reset(reset),
    .load (valid_d[0]),
    .din  (shreg_q),
    .dout (current_phase1)
  );
  current_avg4 u_avg_ph2 (
    .CLK  (CLK),
    .reset(reset),
    .load (valid_d[1]),
    .din  (shreg_q),
    .dout (current_phase2)
  );
  current_avg4 u_avg_ph3 (
    .CLK  (CLK),
    .reset(reset),
    .load (valid_d[2]),
    .din  (shreg_q),
    .dout (current_phase3)
  );
`else
  logic [NUM_CH-1:0][FRAME_BITS-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (valid_d[i]) phase_d[i] = shreg_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign current_phase1 = phase_q[0];
  assign current_phase2 = phase_q[1];
  assign current_phase3 = phase_q[2];
`endif

endmodule

// File: tb/tb_current_sense_spi.sv
// Directed bench for current_sense_spi: a default-timing DUT and a CLK_DIV=4 DUT.
module tb_current_sense_spi;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset, enable, miso, sck;
  logic [2:0]  ss_n, sv;
  logic [15:0] p1, p2, p3;
  logic        reset4, enable4, miso4, sck4;
  logic [2:0]  ss_n4, sv4;
  logic [15:0] q1, q2, q3;

  current_sense_spi u_dut (
    .CLK(CLK), .reset(reset), .enable(enable), .miso(miso), .sck(sck), .ss_n(ss_n),
    .current_phase1(p1), .current_phase2(p2), .current_phase3(p3), .sample_valid(sv)
  );

  current_sense_spi #(.CLK_DIV(4)) u_dut4 (
    .CLK(CLK), .reset(reset4), .enable(enable4), .miso(miso4), .sck(sck4), .ss_n(ss_n4),
    .current_phase1(q1), .current_phase2(q2), .current_phase3(q3), .sample_valid(sv4)
  );

  int unsigned nvec = 0;
  int unsigned nfail = 0;
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ADC model: word loaded when a select falls, next bit driven on each falling SCK.
  logic [15:0] adc_word [3];
  logic [15:0] adc_sh = '0;
  logic        sck_prev = 1'b1;
  logic [2:0]  ss_prev = 3'b111;
  always @(negedge CLK) begin
    if (ss_prev == 3'b111 && ss_n != 3'b111)
      adc_sh = (ss_n == 3'b110) ? adc_word[0] : (ss_n == 3'b101) ? adc_word[1] : adc_word[2];
    if (sck_prev && !sck && ss_n != 3'b111) begin
      miso   = adc_sh[15];
      adc_sh = {adc_sh[14:0], 1'b0};
    end
    sck_prev = sck;
    ss_prev  = ss_n;
  end

  // Late ADC model: drives the wrong bit first, the real bit one clock later.
  logic [15:0] adc4_word, adc4_sh = '0;
  logic        sck4_prev = 1'b1, pend4 = 1'b0, bit4 = 1'b0;
  logic [2:0]  ss4_prev = 3'b111;
  always @(negedge CLK) begin
    if (pend4) begin
      miso4 = bit4;
      pend4 = 1'b0;
    end
    if (ss4_prev == 3'b111 && ss_n4 != 3'b111) adc4_sh = adc4_word;
    if (sck4_prev && !sck4 && ss_n4 != 3'b111) begin
      bit4    = adc4_sh[15];
      miso4   = ~adc4_sh[15];
      pend4   = 1'b1;
      adc4_sh = {adc4_sh[14:0], 1'b0};
    end
    sck4_prev = sck4;
    ss4_prev  = ss_n4;
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ss(input logic [2:0] val, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge CLK);
      if (ss_n == val) ok = 1'b1;
    end
  endtask

  task automatic wait_any_ss(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge CLK);
      if (ss_n != 3'b111) ok = 1'b1;
    end
  endtask

  task automatic wait_sv(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge CLK);
      if (sv != 3'b000) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [2:0]  exp_sv;
    logic [2:0]  exp_ss;
    logic [15:0] exp_word;
  } vec_t;

  vec_t        vecs [3];
  logic        ok;
  int unsigned t0, t_prev, rises, busy;
  logic [2:0]  last_ss;
  logic [15:0] word;

  initial begin
    reset = 1'b1; enable = 1'b0; miso = 1'b0;
    reset4 = 1'b1; enable4 = 1'b0; miso4 = 1'b0;
    adc_word[0] = 16'hA5C3; adc_word[1] = 16'h0222; adc_word[2] = 16'h0333;
    adc4_word = 16'h5AF0;
    vecs[0] = '{exp_sv: 3'b010, exp_ss: 3'b101, exp_word: 16'h0222};
    vecs[1] = '{exp_sv: 3'b100, exp_ss: 3'b011, exp_word: 16'h0333};
    vecs[2] = '{exp_sv: 3'b001, exp_ss: 3'b110, exp_word: 16'h0111};
    repeat (3) @(negedge CLK);
    chk("reset_ss_n", 48'(ss_n), 48'(3'b111));
    chk("reset_sck", 48'(sck), 48'(1'b1));
    chk("reset_phases", {p1, p2, p3}, 48'h0);
    chk("reset_valid", 48'(sv), 48'h0);

`ifdef CURRENT_AVG_EN
    adc_word[0] = 16'h1000;
    reset = 1'b0; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 900 && !ok; i++) begin
        @(negedge CLK);
        if (sv[0]) ok = 1'b1;
      end
      chk("avg_timeout", 48'(ok), 48'(1'b1));
      chk("avg_valid", 48'(sv), 48'(3'b001));
      chk("avg_phase1", 48'(p1), 48'((k < 3) ? 16'h0400 * (k + 1) : 16'h1000));
    end
`else
    // Frame shape on phase 1.
    reset = 1'b0; enable = 1'b1;
    wait_any_ss(20, ok);
    chk("first_select_seen", 48'(ok), 48'(1'b1));
    chk("first_select_ss", 48'(ss_n), 48'(3'b110));
    t0 = cyc; rises = 0; sck_prev_chk: begin end
    ok = 1'b0;
    begin
      logic sp;
      sp = sck;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge CLK);
        if (sck && !sp && ss_n == 3'b110) rises++;
        sp = sck;
        if (sv != 3'b000) ok = 1'b1;
      end
    end
    chk("frame1_timeout", 48'(ok), 48'(1'b1));
    chk("frame1_sck_rises", 48'(rises), 48'(16));
    chk("frame1_latency", 48'(cyc - t0), 48'(260));
    chk("frame1_valid", 48'(sv), 48'(3'b001));
    chk("frame1_phase1", 48'(p1), 48'(16'hA5C3));
    t_prev = cyc;
    adc_word[0] = 16'h0111;
    @(negedge CLK);
    chk("frame1_valid_width", 48'(sv), 48'h0);

    // Rotation and wrap.
    foreach (vecs[v]) begin
      last_ss = 3'b111;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge CLK);
        if (ss_n != 3'b111) last_ss = ss_n;
        if (sv != 3'b000) ok = 1'b1;
      end
      word = (vecs[v].exp_sv == 3'b001) ? p1 : (vecs[v].exp_sv == 3'b010) ? p2 : p3;
      chk("rot_timeout", 48'(ok), 48'(1'b1));
      chk("rot_valid", 48'(sv), 48'(vecs[v].exp_sv));
      chk("rot_ss_n", 48'(last_ss), 48'(vecs[v].exp_ss));
      chk("rot_word", 48'(word), 48'(vecs[v].exp_word));
      chk("rot_period", 48'(cyc - t_prev), 48'(268));
      t_prev = cyc;
    end

    // Drop enable during bit 8 of phase 2.
    adc_word[1] = 16'h0BEE;
    wait_ss(3'b101, 30, ok);
    chk("dis_select_seen", 48'(ok), 48'(1'b1));
    repeat (120) @(negedge CLK);
    enable = 1'b0;
    wait_sv(400, ok);
    chk("dis_timeout", 48'(ok), 48'(1'b1));
    chk("dis_valid", 48'(sv), 48'(3'b010));
    chk("dis_phase2", 48'(p2), 48'(16'h0BEE));
    busy = 0;
    repeat (600) begin
      @(negedge CLK);
      if (ss_n != 3'b111 || sv != 3'b000) busy++;
    end
    chk("dis_quiet", 48'(busy), 48'h0);
    enable = 1'b1;
    wait_any_ss(20, ok);
    chk("resume_seen", 48'(ok), 48'(1'b1));
    chk("resume_ss_n", 48'(ss_n), 48'(3'b011));
    wait_sv(400, ok);
    chk("resume_phase3", 48'(p3), 48'(16'h0333));

    // Reset in the middle of a phase-1 shift.
    wait_ss(3'b110, 30, ok);
    chk("rst_select_seen", 48'(ok), 48'(1'b1));
    repeat (50) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("rst_ss_n", 48'(ss_n), 48'(3'b111));
    chk("rst_sck", 48'(sck), 48'(1'b1));
    chk("rst_phases", {p1, p2, p3}, 48'h0);
    chk("rst_valid", 48'(sv), 48'h0);
    wait_any_ss(20, ok);
    chk("rst_restart_ss_n", 48'(ss_n), 48'(3'b110));
    wait_sv(400, ok);
    chk("rst_restart_phase1", {ok, sv, p1}, {1'b1, 3'b001, 16'h0111});

    // CLK_DIV = 4 instance with late-launch miso.
    enable = 1'b0;
    reset4 = 1'b0; enable4 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (ss_n4 != 3'b111) ok = 1'b1;
    end
    chk("div4_select", {ok, ss_n4}, {1'b1, 3'b110});
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (!sck4) ok = 1'b1;
    end
    t_prev = cyc;
    for (int i = 0; i < 20 && ok; i++) begin
      @(negedge CLK);
      if (sck4) ok = 1'b0;
    end
    chk("div4_half_period", {!ok, 32'(cyc - t_prev)}, {1'b1, 32'd4});
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (sv4 != 3'b000) ok = 1'b1;
    end
    chk("div4_latency", {ok, 32'(cyc - t0)}, {1'b1, 32'd132});
    chk("div4_phase1", {sv4, q1}, {3'b001, 16'h5AF0});
    t_prev = cyc;
    @(negedge CLK);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (sv4 != 3'b000) ok = 1'b1;
    end
    chk("div4_period", {ok, 32'(cyc - t_prev)}, {1'b1, 32'd140});
    chk("div4_phase2", {sv4, q2}, {3'b010, 16'h5AF0});
    enable4 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
